// File: rtl/lcd_axil_seq_pkg.sv
// Shared types and constants for the LCD AXI4-Lite init sequencer.
package lcd_axil_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WRITE  = 3'd1,
      WRESP  = 3'd2,
      READ   = 3'd3,
      RRESP  = 3'd4,
      FINISH = 3'd5
   } seq_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_RESP     = 2'b01;
   localparam logic [1:0] ERR_MISMATCH = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   // AXI4-Lite has no exclusive access, so EXOKAY is as wrong as SLVERR/DECERR.
   function automatic logic resp_is_error(input logic [1:0] resp);
      case (resp)
         RESP_OKAY:   return 1'b0;
         RESP_EXOKAY: return 1'b1;
         default:     return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lcd_axil_seq_watchdog.sv
// Per-state wait watchdog: restarts on every state change, flags after TIMEOUT_CYCLES waiting cycles.
module lcd_axil_seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign expired_o = enable_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

   // next count: reload on state change, saturate once expired
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !expired_o) begin
         count_d = count_q + CW'(1);
      end else begin
         count_d = count_q;
      end
   end

   // count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/lcd_axil_init_sequencer.sv
// AXI4-Lite master writing and reading back NUM_REGS LCD config words.
// Optional per-wait watchdog enabled by defining SEQ_TIMEOUT_EN.
module lcd_axil_init_sequencer
   import lcd_axil_seq_pkg::*;
#(
   parameter int                            C_M_AXI_ADDR_WIDTH = 32,
   parameter int                            C_M_AXI_DATA_WIDTH = 32,
   parameter int                            NUM_REGS           = 4,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
   parameter int                            TIMEOUT_CYCLES     = 256
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic                          start,
   input  logic [NUM_REGS*32-1:0]        cfg_data,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [1:0]                    err_code,
   output logic [3:0]                    err_index,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]                    M_AXI_AWPROT,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic [3:0]                    M_AXI_WSTRB,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;

   seq_state_e             state_q, state_d;
   logic [3:0]             idx_q, idx_d;
   logic [NUM_REGS*32-1:0] cfg_q, cfg_d;
   logic [AW-1:0]          awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DW-1:0]          wdata_q, wdata_d;
   logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                   arvalid_q, arvalid_d, rready_q, rready_d;
   logic                   busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic [1:0]             err_code_q, err_code_d;
   logic [3:0]             err_index_q, err_index_d;
   logic                   fail_s;
   logic [1:0]             fail_code_s;
   logic                   timeout_s;

   function automatic logic [AW-1:0] reg_addr(input logic [3:0] i);
      return BASE_ADDR + AW'({i, 2'b00});
   endfunction

`ifdef SEQ_TIMEOUT_EN
   lcd_axil_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk_i     (ACLK),
      .rst_ni    (ARESETN),
      .clear_i   (state_d != state_q),
      .enable_i  (state_q inside {WRITE, WRESP, READ, RRESP}),
      .expired_o (timeout_s)
   );
`else
   // No watchdog: a negative limit is the only way this can ever be true.
   assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

   // next-state, channel and status decode
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cfg_d       = cfg_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      araddr_d    = araddr_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      err_code_d  = err_code_q;
      err_index_d = err_index_q;
      fail_s      = 1'b0;
      fail_code_s = ERR_NONE;

      case (state_q)
         IDLE: begin
            if (start) begin
               cfg_d       = cfg_data;
               idx_d       = 4'd0;
               busy_d      = 1'b1;
               error_d     = 1'b0;
               err_code_d  = ERR_NONE;
               err_index_d = 4'd0;
               awaddr_d    = reg_addr(4'd0);
               wdata_d     = DW'(cfg_data);
               awvalid_d   = 1'b1;
               wvalid_d    = 1'b1;
               state_d     = WRITE;
            end else begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            awvalid_d = awvalid_q & ~M_AXI_AWREADY;
            wvalid_d  = wvalid_q & ~M_AXI_WREADY;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WRESP;
            end else begin
               state_d = WRITE;
            end
         end
         WRESP: begin
            if (M_AXI_BVALID) begin
               bready_d = 1'b0;
               if (resp_is_error(M_AXI_BRESP)) begin
                  fail_s      = 1'b1;
                  fail_code_s = ERR_RESP;
               end else begin
                  araddr_d  = awaddr_q;
                  arvalid_d = 1'b1;
                  state_d   = READ;
               end
            end else begin
               state_d = WRESP;
            end
         end
         READ: begin
            if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RRESP;
            end else begin
               state_d = READ;
            end
         end
         RRESP: begin
            if (M_AXI_RVALID) begin
               rready_d = 1'b0;
               if (resp_is_error(M_AXI_RRESP)) begin
                  fail_s      = 1'b1;
                  fail_code_s = ERR_RESP;
               end else if (M_AXI_RDATA != wdata_q) begin
                  fail_s      = 1'b1;
                  fail_code_s = ERR_MISMATCH;
               end else if (idx_q == 4'(NUM_REGS - 1)) begin
                  busy_d  = 1'b0;
                  state_d = FINISH;
               end else begin
                  idx_d     = idx_q + 4'd1;
                  awaddr_d  = reg_addr(idx_q + 4'd1);
                  wdata_d   = DW'(cfg_q >> {idx_q + 4'd1, 5'd0});
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WRITE;
               end
            end else begin
               state_d = RRESP;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Watchdog overrides whatever the channel did this cycle.
      if (timeout_s) begin
         fail_s      = 1'b1;
         fail_code_s = ERR_TIMEOUT;
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         bready_d    = 1'b0;
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
      end else begin
         fail_code_s = fail_code_s;
      end

      if (fail_s) begin
         error_d     = 1'b1;
         err_code_d  = fail_code_s;
         err_index_d = idx_q;
         busy_d      = 1'b0;
         state_d     = FINISH;
      end else begin
         error_d = error_d;
      end
   end

   // state and registered outputs
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= IDLE;
         idx_q       <= 4'd0;
         cfg_q       <= '0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         araddr_q    <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_code_q  <= ERR_NONE;
         err_index_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cfg_q       <= cfg_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         araddr_q    <= araddr_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_code_q  <= err_code_d;
         err_index_q <= err_index_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign err_code      = err_code_q;
   assign err_index     = err_index_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_lcd_axil_init_sequencer.sv
// Bench for lcd_axil_init_sequencer: reactive AXI4-Lite memory slave, vector table and random runs.
module tb_lcd_axil_init_sequencer;

   localparam int NREGS = 4;
   localparam int BOUND = 400;

   logic              ACLK = 1'b0;
   logic              ARESETN = 1'b0;
   logic              start = 1'b0;
   logic [NREGS*32-1:0] cfg_data = '0;
   logic              busy, done, error;
   logic [1:0]        err_code;
   logic [3:0]        err_index;
   logic [31:0]       M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
   logic [2:0]        M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]        M_AXI_WSTRB;
   logic              M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]        M_AXI_BRESP, M_AXI_RRESP;
   logic              M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic              M_AXI_RVALID, M_AXI_RREADY;

   always #5 ACLK = ~ACLK;

   lcd_axil_init_sequencer dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
      .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
      .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
      .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
      .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
      .M_AXI_RREADY(M_AXI_RREADY)
   );

   int    n_checks = 0;
   int    n_fail = 0;
   string cur_tag = "init";

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", cur_tag, name, act, exp);
      end
   endtask

   // ---------------- slave knobs and observations ----------------
   int          aw_d = 0, w_d = 0;
   logic [3:0]  bad_b = 4'hF, corrupt = 4'hF, hang_r = 4'hF;
   logic [31:0] mem [16];
   logic [31:0] wlog_addr [$];
   logic [31:0] wlog_data [$];
   int          n_reads = 0, aw_hi = 0, w_hi = 0;
   bit          aw_have, w_have, b_pend, b_bad, r_pend;
   bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
   int          aw_wait, w_wait;
   logic [31:0] aw_addr_l, w_data_l, r_addr_l, hs_aw_addr, hs_w_data, hs_ar_addr;

   task automatic slave_clear();
      aw_have = 0; w_have = 0; b_pend = 0; b_bad = 0; r_pend = 0;
      hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
      aw_wait = 0; w_wait = 0;
   endtask

   // Memory slave: at each negedge, retire handshakes of the last posedge, then drive readies.
   initial begin : slave
      slave_clear();
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            slave_clear();
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0;
         end else begin
            if (hs_aw) begin aw_have = 1; aw_addr_l = hs_aw_addr; end
            if (hs_w)  begin w_have = 1; w_data_l = hs_w_data; end
            if (hs_b)  b_pend = 0;
            if (hs_r)  r_pend = 0;
            if (hs_ar) begin r_pend = 1; r_addr_l = hs_ar_addr; n_reads++; end
            if (aw_have && w_have && !b_pend) begin
               mem[aw_addr_l[5:2]] = w_data_l;
               wlog_addr.push_back(aw_addr_l);
               wlog_data.push_back(w_data_l);
               b_pend = 1; b_bad = (aw_addr_l[5:2] == bad_b);
               aw_have = 0; w_have = 0;
            end
            if (M_AXI_AWVALID && wlog_addr.size() == 0) aw_hi++;
            if (M_AXI_WVALID && wlog_addr.size() == 0) w_hi++;
            if (M_AXI_AWVALID && !aw_have) begin
               if (aw_wait >= aw_d) M_AXI_AWREADY = 1; else begin M_AXI_AWREADY = 0; aw_wait++; end
            end else M_AXI_AWREADY = 0;
            if (M_AXI_WVALID && !w_have) begin
               if (w_wait >= w_d) M_AXI_WREADY = 1; else begin M_AXI_WREADY = 0; w_wait++; end
            end else M_AXI_WREADY = 0;
            M_AXI_BVALID  = b_pend;
            M_AXI_BRESP   = (b_pend && b_bad) ? 2'b10 : 2'b00;
            M_AXI_ARREADY = M_AXI_ARVALID && !r_pend;
            M_AXI_RVALID  = r_pend && (r_addr_l[5:2] != hang_r);
            M_AXI_RDATA   = r_pend ? (mem[r_addr_l[5:2]] ^ ((r_addr_l[5:2] == corrupt) ? 32'h1 : 32'h0)) : 32'h0;
            hs_aw = M_AXI_AWVALID && M_AXI_AWREADY; hs_aw_addr = M_AXI_AWADDR;
            hs_w  = M_AXI_WVALID && M_AXI_WREADY;   hs_w_data  = M_AXI_WDATA;
            if (hs_aw) aw_wait = 0;
            if (hs_w)  w_wait = 0;
            hs_b  = M_AXI_BVALID && M_AXI_BREADY;
            hs_ar = M_AXI_ARVALID && M_AXI_ARREADY; hs_ar_addr = M_AXI_ARADDR;
            hs_r  = M_AXI_RVALID && M_AXI_RREADY;
         end
      end
   end

   // ---------------- reference model ----------------
   // Walk the registers in order: each costs a write phase (2 + slowest ready delay)
   // and a read phase (2); stop at the first bad BRESP or bad readback. Plus 2 for start/done.
   task automatic model(input logic [3:0] bb, input logic [3:0] cr, input int d,
                        output bit e_err, output logic [1:0] e_code, output logic [3:0] e_idx,
                        output int e_wr, output int e_rd, output int e_cyc);
      e_err = 0; e_code = 2'b00; e_idx = 4'd0; e_wr = 0; e_rd = 0; e_cyc = 2;
      for (int i = 0; i < NREGS; i++) begin
         e_wr++; e_cyc += 2 + d;
         if (i == int'(bb)) begin e_err = 1; e_code = 2'b01; e_idx = 4'(i); return; end
         e_rd++; e_cyc += 2;
         if (i == int'(cr)) begin e_err = 1; e_code = 2'b10; e_idx = 4'(i); return; end
      end
   endtask

   task automatic check_quiet(input string name);
      check({name, "_addr"}, {M_AXI_AWADDR, M_AXI_ARADDR}, 64'h0);
      check({name, "_wdata"}, {32'h0, M_AXI_WDATA}, 64'h0);
      check({name, "_ctl"}, {busy, done, error, err_code, err_index, M_AXI_AWVALID, M_AXI_WVALID,
                             M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 64'h0);
   endtask

   task automatic run_seq(input string tag, input logic [NREGS*32-1:0] cfg, input int awd, input int wd,
                          input logic [3:0] bb, input logic [3:0] cr, input logic [3:0] hr, input int inj,
                          input bit e_err, input logic [1:0] e_code, input logic [3:0] e_idx,
                          input int e_wr, input int e_rd, input int e_cyc, input int bound);
      int  cyc;
      bit  seen;
      logic [31:0] w;
      cur_tag = tag;
      @(posedge ACLK);
      aw_d = awd; w_d = wd; bad_b = bb; corrupt = cr; hang_r = hr;
      slave_clear();
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      wlog_addr.delete(); wlog_data.delete();
      n_reads = 0; aw_hi = 0; w_hi = 0;
      @(negedge ACLK);
      start = 1'b1; cfg_data = cfg;
      @(negedge ACLK);
      cyc = 1; seen = 0;
      while (1) begin
         start = (inj != 0 && cyc == inj);
         cfg_data = start ? ~cfg : cfg;
         if (cyc == 1) check("busy_start", {63'h0, busy}, 64'h1);
         if (done) begin seen = 1; break; end
         if (cyc >= bound) break;
         @(negedge ACLK);
         cyc++;
      end
      start = 1'b0; cfg_data = cfg;
      check("done_seen", {63'h0, seen}, 64'h1);
      check("error", {63'h0, error}, {63'h0, e_err});
      check("err_code", {62'h0, err_code}, {62'h0, e_code});
      check("err_index", {60'h0, err_index}, {60'h0, e_idx});
      if (e_cyc >= 0) check("latency", 64'(cyc), 64'(e_cyc));
      check("writes", 64'(wlog_addr.size()), 64'(e_wr));
      check("reads", 64'(n_reads), 64'(e_rd));
      check("awvalid_cycles", 64'(aw_hi), 64'(awd + 1));
      check("wvalid_cycles", 64'(w_hi), 64'(wd + 1));
      for (int i = 0; i < wlog_addr.size(); i++) begin
         w = 32'(cfg >> (32 * i));
         check($sformatf("waddr%0d", i), {32'h0, wlog_addr[i]}, 64'(4 * i));
         check($sformatf("wdata%0d", i), {32'h0, wlog_data[i]}, {32'h0, w});
      end
      @(negedge ACLK);
      check("after_done", {busy, done, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                           M_AXI_RREADY}, 64'h0);
      check("error_sticky", {63'h0, error}, {63'h0, e_err});
   endtask

   typedef struct {
      logic [NREGS*32-1:0] cfg;
      int aw_d; int w_d; logic [3:0] bb; logic [3:0] cr; int inj;
      bit e_err; logic [1:0] e_code; logic [3:0] e_idx; int e_wr; int e_rd; int e_cyc;
   } vec_t;

   localparam logic [NREGS*32-1:0] CFG0 = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF};

   vec_t vecs [6];

   initial begin
      bit          m_err;
      logic [1:0]  m_code;
      logic [3:0]  m_idx;
      int          m_wr, m_rd, m_cyc, d, inj;
      logic [3:0]  bb, cr;
      logic [NREGS*32-1:0] rc;

      vecs[0] = '{CFG0, 0, 0, 4'hF, 4'hF, 0,  1'b0, 2'b00, 4'd0, 4, 4, 18};
      vecs[1] = '{CFG0, 3, 0, 4'hF, 4'hF, 3,  1'b0, 2'b00, 4'd0, 4, 4, 30};
      vecs[2] = '{CFG0, 0, 0, 4'd2, 4'hF, 0,  1'b1, 2'b01, 4'd2, 3, 2, 12};
      vecs[3] = '{CFG0, 0, 0, 4'hF, 4'd1, 0,  1'b1, 2'b10, 4'd1, 2, 2, 10};
      vecs[4] = '{CFG0, 1, 2, 4'hF, 4'hF, 25, 1'b0, 2'b00, 4'd0, 4, 4, 26};
      vecs[5] = '{CFG0, 0, 1, 4'd0, 4'hF, 0,  1'b1, 2'b01, 4'd0, 1, 0, 5};

      cur_tag = "reset";
      repeat (3) @(negedge ACLK);
      check_quiet("reset");
      check("consts", {54'h0, M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}, {54'h0, 3'b000, 3'b000, 4'hF});
      ARESETN = 1'b1;

      for (int v = 0; v < 6; v++)
         run_seq($sformatf("vec%0d", v), vecs[v].cfg, vecs[v].aw_d, vecs[v].w_d, vecs[v].bb, vecs[v].cr,
                 4'hF, vecs[v].inj, vecs[v].e_err, vecs[v].e_code, vecs[v].e_idx, vecs[v].e_wr,
                 vecs[v].e_rd, vecs[v].e_cyc, BOUND);

      // Reset in the middle of a stalled write, then a clean restart.
      cur_tag = "reset_mid";
      @(posedge ACLK);
      aw_d = 6; w_d = 0; bad_b = 4'hF; corrupt = 4'hF; hang_r = 4'hF;
      @(negedge ACLK);
      start = 1'b1; cfg_data = CFG0;
      @(negedge ACLK);
      start = 1'b0;
      @(negedge ACLK);
      check("awvalid_held", {63'h0, M_AXI_AWVALID}, 64'h1);
      #2 ARESETN = 1'b0;
      #1 check_quiet("in_reset");
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      run_seq("after_reset", CFG0, 0, 0, 4'hF, 4'hF, 4'hF, 0, 1'b0, 2'b00, 4'd0, 4, 4, 18, BOUND);

      for (int it = 0; it < 24; it++) begin
         rc = {$urandom(), $urandom(), $urandom(), $urandom()};
         aw_d = $urandom_range(0, 3);
         w_d  = $urandom_range(0, 3);
         bb = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 3)) : 4'hF;
         cr = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 3)) : 4'hF;
         d = (aw_d > w_d) ? aw_d : w_d;
         model(bb, cr, d, m_err, m_code, m_idx, m_wr, m_rd, m_cyc);
         case ($urandom_range(0, 2))
            0:       inj = 0;
            1:       inj = 3;
            default: inj = m_cyc - 1;
         endcase
         run_seq($sformatf("rand%0d", it), rc, aw_d, w_d, bb, cr, 4'hF, inj,
                 m_err, m_code, m_idx, m_wr, m_rd, m_cyc, BOUND);
      end

`ifdef SEQ_TIMEOUT_EN
      run_seq("timeout", CFG0, 0, 0, 4'hF, 4'hF, 4'd0, 0, 1'b1, 2'b11, 4'd0, 1, 1, -1, 2000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
